csr_iq_drain: RTL and testbench
===============================

Name: csr_iq_drain

Overview:
- Consumer end of the CSR instruction queue: pops one queued CSR op per transaction once the ROB permits.
- Performs read-modify-write on the CSR file through a req/ack handshake, then writes the old CSR value back to the integer register file.
- Sits between the CSR instruction queue (read port side) and the CSR register file / writeback arbiter.
- Strictly serial: at most one op in flight.

Parameters:
- CRIQWIDE, 23, queue entry width; fields are [22:21] op, [20:7] csr num, [6:2] rd, [1:0] rob tag.
- CSRNUMW, 14, CSR number width.
- DATAW, 32, CSR data width.
- TMOUT, 15, ack timeout in cycles (used only with the feature macro).

Ports:
- Clk  in  1  clock.
- Rest  in  1  asynchronous active-low reset.
- CriqEmpty  in  1  queue empty.
- Rable  out  1  queue pop strobe, one cycle wide.
- Dout  in  CRIQWIDE  popped entry, valid the cycle after Rable.
- CommitOk  in  1  ROB: head CSR op is oldest and may execute.
- OpData  in  DATAW  new value (rd operand), sampled with Dout.
- OpMask  in  DATAW  xchg mask (rj operand), sampled with Dout.
- Flush  in  1  pipeline flush.
- CsrReq  out  1  CSR access request.
- CsrWe  out  1  1 = write, 0 = read.
- CsrAddr  out  CSRNUMW  CSR number.
- CsrWdata  out  DATAW  write data.
- CsrAck  in  1  access done; CsrRdata valid in the same cycle.
- CsrRdata  in  DATAW  read data.
- WbValid  out  1  writeback pulse.
- WbReg  out  5  destination register.
- WbData  out  DATAW  old CSR value.
- WbTag  out  2  rob tag.
- Busy  out  1  state != IDLE.
- IllegalOp  out  1  one-cycle pulse for op==11.

Behaviour:
- Reset (async, Rest low): state IDLE; all outputs 0; captured fields 0.
- States: IDLE, POP, CAPT, RD, WR, WB.
- IDLE -> POP when !CriqEmpty && CommitOk && !Flush.
- POP: Rable=1 for exactly this cycle; -> CAPT.
- CAPT: latch Dout, OpData and OpMask.
  - op==11: IllegalOp pulse, -> IDLE with no CSR access.
  - otherwise -> RD.
- RD: CsrReq=1, CsrWe=0, CsrAddr=csr num; hold until CsrAck.
  - On ack, latch old=CsrRdata.
  - op==00 -> WB; else -> WR.
- WR: CsrReq=1, CsrWe=1.
  - CsrWdata = OpData for op 01; (old & ~OpMask) | (OpData & OpMask) for op 10.
  - Hold until CsrAck, then -> WB.
- WB: WbValid=1 for one cycle; WbReg=rd, WbData=old, WbTag=tag; -> IDLE.
- CSR outputs are held stable while CsrReq=1 and ack=0.
- Minimum latency, IDLE-to-WbValid:
  - op 00: 4 cycles with ack in the first cycle of RD.
  - op 01/10: 5 cycles.
- Flush:
  - In POP, CAPT or RD: abandon and go to IDLE next cycle; no write, no WbValid. The popped entry is discarded and the queue is cleaned by its owner.
  - In WR or WB: ignored; the op completes, because the CSR side effect is committed.
- Flush together with CsrAck in RD: flush wins; the read is discarded.
- CommitOk deasserting after POP has no effect.
- Back-to-back ops: IDLE is re-entered for one cycle between ops, so pops are at least 5 cycles apart.
- Rable is never asserted while CriqEmpty=1.

Optional Feature:
- Macro: CSR_DRAIN_TIMEOUT_EN.
- With the macro:
  - A 4-bit counter runs while in RD or WR with no ack.
  - On reaching TMOUT, drop CsrReq, pulse extra output port CsrTimeout for 1 cycle, and go to IDLE with no WbValid.
  - The counter clears on each state entry.
- Without the macro: no counter and no CsrTimeout port; the block waits indefinitely for ack.

Decomposition:
- Shared package/include (IPsetting.v style):
  - op encodings CSR_OP_RD=2'b00, CSR_OP_WR=2'b01, CSR_OP_XCHG=2'b10.
  - entry field bit positions.
  - state encodings.
  - CSRNUMW and DATAW defaults.
- Sub-module csr_rmw_merge: combinational write-data merge (op, old, data, mask -> wdata), reused by the exception path.

Test Plan:
- csrrd: entry {00, 14'h0005, rd=3, tag=1}, CsrRdata=32'hA5A5_0001, ack after 2 cycles -> one Rable, no write, WbValid with WbReg=3, WbData=32'hA5A5_0001, WbTag=1.
- csrxchg: old=32'hFFFF_0000, OpData=32'h1234_5678, OpMask=32'h00FF_00FF -> CsrWdata=32'hFF34_0078, WbData=32'hFFFF_0000.
- Flush in RD cycle 2 -> no CsrWe, no WbValid, Busy=0 next cycle; Flush in WR -> write and WbValid still occur.
- CriqEmpty=1 with CommitOk=1 for 10 cycles -> Rable never asserted; op==11 -> IllegalOp pulse, CsrReq never asserted.
- Rest asserted low mid-WR -> all outputs 0 immediately (async), state IDLE; after release the next op runs normally.
- With CSR_DRAIN_TIMEOUT_EN: ack withheld -> CsrReq drops and CsrTimeout pulses after 15 cycles in RD, no WbValid.

Source files
------------

// File: rtl/csr_iq_drain_pkg.sv
// Shared definitions for the CSR instruction-queue drain: entry layout, op and state encodings.
// CSR_DRAIN_TIMEOUT_EN (in the top) is the only consumer of TMOUT.
package csr_iq_drain_pkg;

    localparam int CRIQWIDE = 23;
    localparam int CSRNUMW  = 14;
    localparam int DATAW    = 32;
    localparam int TMOUT    = 15;

    localparam int OP_HI  = 22;
    localparam int OP_LO  = 21;
    localparam int CSR_HI = 20;
    localparam int CSR_LO = 7;
    localparam int RD_HI  = 6;
    localparam int RD_LO  = 2;
    localparam int TAG_HI = 1;
    localparam int TAG_LO = 0;

    typedef enum logic [1:0] {
        CSR_OP_RD   = 2'b00,
        CSR_OP_WR   = 2'b01,
        CSR_OP_XCHG = 2'b10,
        CSR_OP_ILL  = 2'b11
    } csr_op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_POP  = 3'd1,
        ST_CAPT = 3'd2,
        ST_RD   = 3'd3,
        ST_WR   = 3'd4,
        ST_WB   = 3'd5
    } state_e;

    typedef struct packed {
        csr_op_e            op;
        logic [CSRNUMW-1:0] csr;
        logic [4:0]         rd;
        logic [1:0]         tag;
    } criq_entry_t;

endpackage

// File: rtl/csr_rmw_merge.sv
// Combinational CSR write-data merge; shared with the exception path.
module csr_rmw_merge
    import csr_iq_drain_pkg::*;
(
    input  logic [1:0]       op,
    input  logic [DATAW-1:0] old,
    input  logic [DATAW-1:0] data,
    input  logic [DATAW-1:0] mask,
    output logic [DATAW-1:0] wdata
);

    always_comb begin
        case (csr_op_e'(op))
            CSR_OP_WR:   wdata = data;
            CSR_OP_XCHG: wdata = (old & ~mask) | (data & mask);
            default:     wdata = old;
        endcase
    end

endmodule

// File: rtl/csr_iq_drain.sv
// Serial consumer of the CSR instruction queue: pop, CSR read-modify-write, old value writeback.
// Define CSR_DRAIN_TIMEOUT_EN to add the ack timeout and the CsrTimeout port.
module csr_iq_drain
    import csr_iq_drain_pkg::*;
(
    input  logic                Clk,
    input  logic                Rest,
    input  logic                CriqEmpty,
    output logic                Rable,
    input  logic [CRIQWIDE-1:0] Dout,
    input  logic                CommitOk,
    input  logic [DATAW-1:0]    OpData,
    input  logic [DATAW-1:0]    OpMask,
    input  logic                Flush,
    output logic                CsrReq,
    output logic                CsrWe,
    output logic [CSRNUMW-1:0]  CsrAddr,
    output logic [DATAW-1:0]    CsrWdata,
    input  logic                CsrAck,
    input  logic [DATAW-1:0]    CsrRdata,
    output logic                WbValid,
    output logic [4:0]          WbReg,
    output logic [DATAW-1:0]    WbData,
    output logic [1:0]          WbTag,
`ifdef CSR_DRAIN_TIMEOUT_EN
    output logic                CsrTimeout,
`endif
    output logic                Busy,
    output logic                IllegalOp
);

    state_e           state_q, state_d;
    criq_entry_t      entry_q, entry_d;
    logic [DATAW-1:0] data_q, data_d;
    logic [DATAW-1:0] mask_q, mask_d;
    logic [DATAW-1:0] old_q, old_d;
    logic [DATAW-1:0] merge_wdata;

`ifdef CSR_DRAIN_TIMEOUT_EN
    localparam logic [3:0] TMOUT_CNT = 4'(TMOUT);
    logic [3:0] tmo_cnt_q, tmo_cnt_d;
`endif

    csr_rmw_merge u_merge (
        .op    (entry_q.op),
        .old   (old_q),
        .data  (data_q),
        .mask  (mask_q),
        .wdata (merge_wdata)
    );

    assign Busy = (state_q != ST_IDLE);

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            state_q   <= ST_IDLE;
            entry_q   <= '0;
            data_q    <= '0;
            mask_q    <= '0;
            old_q     <= '0;
`ifdef CSR_DRAIN_TIMEOUT_EN
            tmo_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            entry_q   <= entry_d;
            data_q    <= data_d;
            mask_q    <= mask_d;
            old_q     <= old_d;
`ifdef CSR_DRAIN_TIMEOUT_EN
            tmo_cnt_q <= tmo_cnt_d;
`endif
        end
    end

    always_comb begin
        // NOTE: every variable written here gets a default first, so no latch can be inferred.
        state_d   = state_q;
        entry_d   = entry_q;
        data_d    = data_q;
        mask_d    = mask_q;
        old_d     = old_q;
        Rable     = 1'b0;
        CsrReq    = 1'b0;
        CsrWe     = 1'b0;
        CsrAddr   = '0;
        CsrWdata  = '0;
        WbValid   = 1'b0;
        WbReg     = '0;
        WbData    = '0;
        WbTag     = '0;
        IllegalOp = 1'b0;
`ifdef CSR_DRAIN_TIMEOUT_EN
        CsrTimeout = 1'b0;
        tmo_cnt_d  = tmo_cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (!CriqEmpty && CommitOk && !Flush) state_d = ST_POP;
            end
            ST_POP: begin
                // A flushed pop still consumes the entry; the queue owner cleans up.
                Rable   = !CriqEmpty;
                state_d = (Flush || CriqEmpty) ? ST_IDLE : ST_CAPT;
            end
            ST_CAPT: begin
                entry_d.op  = csr_op_e'(Dout[OP_HI:OP_LO]);
                entry_d.csr = Dout[CSR_HI:CSR_LO];
                entry_d.rd  = Dout[RD_HI:RD_LO];
                entry_d.tag = Dout[TAG_HI:TAG_LO];
                data_d      = OpData;
                mask_d      = OpMask;
                if (Flush) begin
                    state_d = ST_IDLE;
                end else if (csr_op_e'(Dout[OP_HI:OP_LO]) == CSR_OP_ILL) begin
                    IllegalOp = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = ST_RD;
                end
            end
            ST_RD: begin
                CsrReq  = 1'b1;
                CsrAddr = entry_q.csr;
                if (Flush) begin
                    state_d = ST_IDLE;
                end else if (CsrAck) begin
                    old_d   = CsrRdata;
                    state_d = (entry_q.op == CSR_OP_RD) ? ST_WB : ST_WR;
                end
            end
            ST_WR: begin
                // The side effect is committed once here, so Flush is ignored.
                CsrReq   = 1'b1;
                CsrWe    = 1'b1;
                CsrAddr  = entry_q.csr;
                CsrWdata = merge_wdata;
                if (CsrAck) state_d = ST_WB;
            end
            ST_WB: begin
                WbValid = 1'b1;
                WbReg   = entry_q.rd;
                WbData  = old_q;
                WbTag   = entry_q.tag;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef CSR_DRAIN_TIMEOUT_EN
        if ((state_q == ST_RD || state_q == ST_WR) && tmo_cnt_q == TMOUT_CNT) begin
            CsrReq     = 1'b0;
            CsrWe      = 1'b0;
            CsrAddr    = '0;
            CsrWdata   = '0;
            CsrTimeout = 1'b1;
            old_d      = old_q;
            state_d    = ST_IDLE;
        end
        if (state_d != state_q) begin
            tmo_cnt_d = '0;
        end else if ((state_q == ST_RD || state_q == ST_WR) && !CsrAck) begin
            tmo_cnt_d = tmo_cnt_q + 4'd1;
        end
`endif
    end

endmodule

// File: tb/tb_csr_iq_drain.sv
// Directed bench for csr_iq_drain with a CSR-side responder and a scoreboard monitor.
module tb_csr_iq_drain;
    import csr_iq_drain_pkg::*;

    logic                Clk = 1'b0;
    logic                Rest = 1'b0;
    logic                CriqEmpty = 1'b1;
    logic                Rable;
    logic [CRIQWIDE-1:0] Dout = '0;
    logic                CommitOk = 1'b0;
    logic [DATAW-1:0]    OpData = '0;
    logic [DATAW-1:0]    OpMask = '0;
    logic                Flush = 1'b0;
    logic                CsrReq, CsrWe;
    logic [CSRNUMW-1:0]  CsrAddr;
    logic [DATAW-1:0]    CsrWdata;
    logic                CsrAck = 1'b0;
    logic [DATAW-1:0]    CsrRdata = '0;
    logic                WbValid;
    logic [4:0]          WbReg;
    logic [DATAW-1:0]    WbData;
    logic [1:0]          WbTag;
    logic                Busy, IllegalOp;
`ifdef CSR_DRAIN_TIMEOUT_EN
    logic                CsrTimeout;
`endif

    csr_iq_drain dut (
        .Clk(Clk), .Rest(Rest), .CriqEmpty(CriqEmpty), .Rable(Rable), .Dout(Dout),
        .CommitOk(CommitOk), .OpData(OpData), .OpMask(OpMask), .Flush(Flush),
        .CsrReq(CsrReq), .CsrWe(CsrWe), .CsrAddr(CsrAddr), .CsrWdata(CsrWdata),
        .CsrAck(CsrAck), .CsrRdata(CsrRdata), .WbValid(WbValid), .WbReg(WbReg),
        .WbData(WbData), .WbTag(WbTag),
`ifdef CSR_DRAIN_TIMEOUT_EN
        .CsrTimeout(CsrTimeout),
`endif
        .Busy(Busy), .IllegalOp(IllegalOp)
    );

    always #5 Clk = ~Clk;

    typedef struct { logic [CSRNUMW-1:0] addr; logic [DATAW-1:0] data; } wr_t;
    typedef struct { logic [4:0] rg; logic [DATAW-1:0] data; logic [1:0] tag; } wb_t;
    wr_t exp_wr[$];
    wb_t exp_wb[$];

    int n_cmp = 0, n_bad = 0;
    int ack_delay = 0, wait_cnt = 0;
    logic [DATAW-1:0] rdata_val = '0;
    int cyc = 0, last_pop = -1;
    int rable_cnt = 0, wb_cnt = 0, wr_cnt = 0, we_cyc = 0, ill_cnt = 0, req_cyc = 0, tmo_cnt = 0;
    int b_rable, b_wb, b_wr, b_we, b_ill, b_req, b_tmo;
    logic prev_req = 0, prev_ack = 0, prev_we = 0;
    logic [CSRNUMW-1:0] prev_addr = '0;
    logic [DATAW-1:0]   prev_wdata = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 'h%0h, want 'h%0h", name, act, exp);
        end
    endtask

    // CSR file model: ack arrives in the (ack_delay+1)-th cycle of each request.
    initial begin
        forever begin
            @(posedge Clk); #1;
            CsrRdata = rdata_val;
            if (CsrReq && wait_cnt >= ack_delay) begin
                CsrAck   = 1'b1;
                wait_cnt = 0;
            end else begin
                CsrAck   = 1'b0;
                wait_cnt = CsrReq ? wait_cnt + 1 : 0;
            end
        end
    end

    // Monitor: pops expected CSR writes and writebacks as the DUT presents them.
    initial begin
        wr_t ew;
        wb_t eb;
        forever begin
            @(negedge Clk);
            cyc++;
            if (Rable) begin
                check("rable_while_empty", CriqEmpty, 0);
                if (last_pop >= 0) check("pop_gap_ge5", (cyc - last_pop) >= 5, 1);
                last_pop = cyc;
                rable_cnt++;
            end
            if (IllegalOp) ill_cnt++;
            if (CsrReq) req_cyc++;
            if (CsrWe) we_cyc++;
`ifdef CSR_DRAIN_TIMEOUT_EN
            if (CsrTimeout) tmo_cnt++;
`endif
            if (CsrReq && prev_req && !prev_ack)
                check("csr_hold_stable", {CsrWe, CsrAddr, CsrWdata}, {prev_we, prev_addr, prev_wdata});
            if (CsrReq && CsrWe && CsrAck) begin
                wr_cnt++;
                if (exp_wr.size() == 0) check("unexpected_write", 1, 0);
                else begin
                    ew = exp_wr.pop_front();
                    check("wr_addr", CsrAddr, ew.addr);
                    check("wr_data", CsrWdata, ew.data);
                end
            end
            if (WbValid) begin
                wb_cnt++;
                if (exp_wb.size() == 0) check("unexpected_wb", 1, 0);
                else begin
                    eb = exp_wb.pop_front();
                    check("wb_reg", WbReg, eb.rg);
                    check("wb_data", WbData, eb.data);
                    check("wb_tag", WbTag, eb.tag);
                end
            end
            prev_req = CsrReq; prev_ack = CsrAck; prev_we = CsrWe;
            prev_addr = CsrAddr; prev_wdata = CsrWdata;
        end
    end

    task automatic snap();
        b_rable = rable_cnt; b_wb = wb_cnt; b_wr = wr_cnt; b_we = we_cyc;
        b_ill = ill_cnt; b_req = req_cyc; b_tmo = tmo_cnt;
    endtask

    // mode: 0 plain, 1 drop CommitOk after pop, 2 Flush in 2nd RD cycle, 3 Flush from WR on, 4 reset in WR
    task automatic run_op(input logic [CRIQWIDE-1:0] ent, input logic [DATAW-1:0] data,
                          input logic [DATAW-1:0] mask, input logic [DATAW-1:0] rdata,
                          input int dly, input int mode, output int lat);
        int  req_seen = 0, flush_i = -1;
        bit  popped = 0, done = 0, we_seen = 0;
        lat = -1;
        @(posedge Clk); #1;
        Dout = ent; OpData = data; OpMask = mask; rdata_val = rdata; ack_delay = dly;
        CriqEmpty = 1'b0; CommitOk = 1'b1;
        for (int i = 0; i < 80 && !done; i++) begin
            @(negedge Clk);
            if (WbValid && lat < 0) lat = i;
            if (mode == 2 && Flush) flush_i = i;
            if (mode == 2 && flush_i >= 0 && i == flush_i + 1) check("flush_busy_next", Busy, 0);
            if (popped && !Busy) done = 1;
            if (Rable) popped = 1;
            if (CsrReq) req_seen++;
            if (CsrWe) we_seen = 1;
            if (mode == 4 && CsrWe && Rest) begin
                #2 Rest = 1'b0;
                #1 check("async_reset_outs",
                         {Rable, CsrReq, CsrWe, CsrAddr, CsrWdata, WbValid, IllegalOp, Busy}, 0);
                check("async_reset_wb", {WbReg, WbData, WbTag}, 0);
            end
            @(posedge Clk); #1;
            if (!Rest) Rest = 1'b1;
            if (popped) begin
                CriqEmpty = 1'b1;
                if (mode == 1) CommitOk = 1'b0;
            end
            Flush = (mode == 2 && req_seen == 1) || (mode == 3 && we_seen);
        end
        if (!done) check("op_completes_in_budget", 0, 1);
        Flush = 1'b0;
    endtask

    initial begin
        int lat;
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("reset_outs", {Rable, CsrReq, CsrWe, CsrAddr, CsrWdata, WbValid, IllegalOp, Busy}, 0);
        check("reset_wb", {WbReg, WbData, WbTag}, 0);
        @(posedge Clk); #1 Rest = 1'b1;

        // csrrd, ack in the third RD cycle
        snap();
        exp_wb.push_back('{rg: 5'd3, data: 32'hA5A5_0001, tag: 2'd1});
        run_op({2'b00, 14'h0005, 5'd3, 2'd1}, 32'h0, 32'h0, 32'hA5A5_0001, 2, 0, lat);
        check("rd_pops", rable_cnt - b_rable, 1);
        check("rd_no_write", we_cyc - b_we, 0);
        check("rd_wb_count", wb_cnt - b_wb, 1);
        check("rd_latency", lat, 6);

        // csrxchg, CommitOk drops after the pop
        snap();
        exp_wr.push_back('{addr: 14'h0300, data: 32'hFF34_0078});
        exp_wb.push_back('{rg: 5'd7, data: 32'hFFFF_0000, tag: 2'd2});
        run_op({2'b10, 14'h0300, 5'd7, 2'd2}, 32'h1234_5678, 32'h00FF_00FF, 32'hFFFF_0000, 1, 1, lat);
        check("xchg_writes", wr_cnt - b_wr, 1);
        check("xchg_latency", lat, 7);

        // minimum latency, read, max CSR number
        snap();
        exp_wb.push_back('{rg: 5'd0, data: 32'h8000_0001, tag: 2'd0});
        run_op({2'b00, 14'h3FFF, 5'd0, 2'd0}, 32'h0, 32'h0, 32'h8000_0001, 0, 0, lat);
        check("rd_min_latency", lat, 4);

        // Flush in the 2nd RD cycle, then Flush coinciding with ack
        snap();
        run_op({2'b01, 14'h0010, 5'd4, 2'd2}, 32'h1111_2222, 32'h0, 32'h3333_4444, 5, 2, lat);
        check("flush_rd_no_we", we_cyc - b_we, 0);
        check("flush_rd_no_wb", wb_cnt - b_wb, 0);
        snap();
        run_op({2'b00, 14'h0011, 5'd5, 2'd1}, 32'h0, 32'h0, 32'h5555_6666, 1, 2, lat);
        check("flush_ack_no_wb", wb_cnt - b_wb, 0);

        // Flush in WR is ignored
        snap();
        exp_wr.push_back('{addr: 14'h0020, data: 32'hA0A0_5F5F});
        exp_wb.push_back('{rg: 5'd9, data: 32'h0000_FFFF, tag: 2'd0});
        run_op({2'b10, 14'h0020, 5'd9, 2'd0}, 32'hAAAA_5555, 32'hF0F0_F0F0, 32'h0000_FFFF, 2, 3, lat);
        check("flush_wr_wb", wb_cnt - b_wb, 1);

        // empty queue with CommitOk: no pops
        snap();
        @(posedge Clk); #1 CriqEmpty = 1'b1; CommitOk = 1'b1;
        repeat (10) @(posedge Clk);
        check("empty_no_pop", rable_cnt - b_rable, 0);

        // illegal op
        snap();
        run_op({2'b11, 14'h0007, 5'd1, 2'd1}, 32'h0, 32'h0, 32'h0, 0, 0, lat);
        check("ill_pulse", ill_cnt - b_ill, 1);
        check("ill_no_req", req_cyc - b_req, 0);
        check("ill_no_wb", wb_cnt - b_wb, 0);

        // async reset mid-WR, then a normal csrwr
        snap();
        run_op({2'b01, 14'h0055, 5'd2, 2'd3}, 32'h7777_8888, 32'h0, 32'h9999_AAAA, 6, 4, lat);
        check("reset_wr_no_wb", wb_cnt - b_wb, 0);
        snap();
        exp_wr.push_back('{addr: 14'h01A2, data: 32'hCAFE_BABE});
        exp_wb.push_back('{rg: 5'd31, data: 32'h0BAD_F00D, tag: 2'd3});
        run_op({2'b01, 14'h01A2, 5'd31, 2'd3}, 32'hCAFE_BABE, 32'h0, 32'h0BAD_F00D, 0, 0, lat);
        check("wr_min_latency", lat, 5);
        check("wr_after_reset_wb", wb_cnt - b_wb, 1);

`ifdef CSR_DRAIN_TIMEOUT_EN
        snap();
        run_op({2'b00, 14'h0040, 5'd6, 2'd0}, 32'h0, 32'h0, 32'h1, 100, 0, lat);
        check("tmo_pulse", tmo_cnt - b_tmo, 1);
        check("tmo_req_cycles", req_cyc - b_req, 15);
        check("tmo_no_wb", wb_cnt - b_wb, 0);
`endif

        repeat (3) @(posedge Clk);
        check("exp_wr_drained", exp_wr.size(), 0);
        check("exp_wb_drained", exp_wb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
